// File: rtl/mem_bus_sequencer.sv
// External-memory bus-cycle engine: ALE/nME/nOE/nWE sequencing on a
// multiplexed address/data bus with wait states, Ready and timeout.
module mem_bus_sequencer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int WAIT_W     = 4,
  parameter int FETCH_WAIT = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              ReqWrite,
  input  logic              ReqFetch,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  input  logic [WAIT_W-1:0] DataWait,
  input  logic              Ready,
  input  logic [DATA_W-1:0] AdIn,
  output logic [DATA_W-1:0] AdOut,
  output logic              AdOe,
  output logic              ALE,
  output logic              nME,
  output logic              nOE,
  output logic              nWE,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [DATA_W-1:0] RData
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_SETUP,
    S_WAIT,
    S_DATA,
    S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] adout_q, adout_d;
  logic              adoe_q, adoe_d;
  logic              ale_q, ale_d;
  logic              nme_q, nme_d;
  logic              noe_q, noe_d;
  logic              nwe_q, nwe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (Req) begin
          state_d = S_ADDR;
          write_d = ReqWrite;
          addr_d  = Addr;
          wdata_d = WData;
          err_d   = 1'b0;
          wait_d  = (ReqFetch && !ReqWrite) ?
                    WAIT_W'(FETCH_WAIT) : DataWait;
        end
      end
      S_ADDR: state_d = S_SETUP;
      S_SETUP: begin
        if (wait_q == '0 && Ready) begin
          state_d = S_DATA;
        end else begin
          // The last wait cycle is also the first Ready check.
          state_d = S_WAIT;
          cnt_d   = (wait_q == '0) ? '0 : wait_q - WAIT_W'(1);
          tcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else if (Ready) begin
          state_d = S_DATA;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_HOLD;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DATA: begin
        state_d = S_HOLD;
        if (!write_q) rdata_d = AdIn;
      end
      S_HOLD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are decoded from the next state so every output is a flop.
  always_comb begin
    adout_d = adout_q;
    adoe_d  = 1'b0;
    ale_d   = 1'b0;
    nme_d   = 1'b1;
    noe_d   = 1'b1;
    nwe_d   = 1'b1;
    busy_d  = (state_d != S_IDLE);
    done_d  = 1'b0;
    error_d = 1'b0;
    unique case (state_d)
      S_ADDR: begin
        ale_d   = 1'b1;
        nme_d   = 1'b0;
        adoe_d  = 1'b1;
        adout_d = DATA_W'(addr_d);
      end
      S_SETUP, S_WAIT, S_DATA: begin
        nme_d = 1'b0;
        if (write_d) begin
          adoe_d  = 1'b1;
          adout_d = wdata_d;
          nwe_d   = 1'b0;
        end else begin
          noe_d = 1'b0;
        end
      end
      S_HOLD: begin
        done_d  = 1'b1;
        error_d = err_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      adout_q <= '0;
      adoe_q  <= 1'b0;
      ale_q   <= 1'b0;
      nme_q   <= 1'b1;
      noe_q   <= 1'b1;
      nwe_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      adout_q <= adout_d;
      adoe_q  <= adoe_d;
      ale_q   <= ale_d;
      nme_q   <= nme_d;
      noe_q   <= noe_d;
      nwe_q   <= nwe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign AdOut = adout_q;
  assign AdOe  = adoe_q;
  assign ALE   = ale_q;
  assign nME   = nme_q;
  assign nOE   = noe_q;
  assign nWE   = nwe_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Error = error_q;
  assign RData = rdata_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: directed scenarios plus random
// transactions checked cycle by cycle against a latency/pin model.
module tb_mem_bus_sequencer;

  localparam int FW = 2;
  localparam int TO = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req, ReqWrite, ReqFetch, Ready;
  logic [15:0] Addr, WData, AdIn, AdOut, RData;
  logic [3:0]  DataWait;
  logic        AdOe, ALE, nME, nOE, nWE, Busy, Done, Error;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_done = 0;
  logic [15:0] rdata_exp = '0;
  logic [15:0] adin_v [32];

  mem_bus_sequencer #(
    .DATA_W(16), .ADDR_W(16), .WAIT_W(4),
    .FETCH_WAIT(FW), .TIMEOUT(TO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req),
    .ReqWrite(ReqWrite), .ReqFetch(ReqFetch),
    .Addr(Addr), .WData(WData), .DataWait(DataWait),
    .Ready(Ready), .AdIn(AdIn), .AdOut(AdOut), .AdOe(AdOe),
    .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE),
    .Busy(Busy), .Done(Done), .Error(Error), .RData(RData)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // One transaction: model the cycle of Done from the wait/Ready rules,
  // then compare the pins of every cycle until the bus is idle again.
  task automatic run_txn(input bit wr, input bit fe,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic [3:0] dw, input logic [31:0] mask,
                         input bit hold, input bit fix,
                         input logic [15:0] fixv, input string nm);
    int w, c, lows, dc, datac;
    bit err;
    logic [7:0]  ev, gv;
    logic [15:0] ead;
    bit          chk_ad;
    w = (fe && !wr) ? FW : int'(dw);
    c = 2 + w;
    lows = 0; dc = 0; datac = 0; err = 0;
    while (dc == 0) begin
      if (mask[c]) begin
        datac = c + 1;
        dc = c + 2;
      end else begin
        if (c > 2) begin
          lows++;
          if (lows == TO) begin
            dc = c + 1;
            err = 1;
          end
        end
        c++;
      end
    end
    for (int k = 0; k < 32; k++) adin_v[k] = fix ? fixv : 16'($urandom);
    Req = 1; ReqWrite = wr; ReqFetch = fe;
    Addr = a; WData = d; DataWait = dw;
    @(posedge Clock); #1;
    if (!hold) Req = 0;
    ReqWrite = 1'($urandom); ReqFetch = 1'($urandom);
    Addr = 16'($urandom); WData = 16'($urandom);
    DataWait = 4'($urandom);
    for (int k = 1; k <= dc + 1; k++) begin
      chk_ad = 0; ead = '0;
      if (k == 1) begin
        ev = 8'b1011_1100; chk_ad = 1; ead = a;
      end else if (k < dc) begin
        if (wr) begin
          ev = 8'b0010_1100; chk_ad = 1; ead = d;
        end else begin
          ev = 8'b0001_0100;
        end
      end else if (k == dc) begin
        ev = {7'b0111_011, err};
      end else begin
        ev = 8'b0111_0000;
      end
      gv = {ALE, nME, nOE, nWE, AdOe, Busy, Done, Error};
      checks++;
      if (gv !== ev)
        $display("FAIL %s pins cyc%0d got=%b want=%b", nm, k, gv, ev);
      if (gv !== ev) errors++;
      if (chk_ad) begin
        checks++;
        if (AdOut !== ead) begin
          errors++;
          $display("FAIL %s adout cyc%0d got=%h want=%h",
                   nm, k, AdOut, ead);
        end
      end
      checks++;
      if (AdOe === 1'b1 && nOE === 1'b0) begin
        errors++;
        $display("FAIL %s turnaround cyc%0d AdOe=1 nOE=0", nm, k);
      end
      if (k == dc) begin
        last_done = cyc;
        if (!wr && !err) rdata_exp = adin_v[datac];
      end
      checks++;
      if (RData !== rdata_exp) begin
        errors++;
        $display("FAIL %s rdata cyc%0d got=%h want=%h",
                 nm, k, RData, rdata_exp);
      end
      Ready = mask[k];
      AdIn = adin_v[k];
      if (k <= dc) begin
        @(posedge Clock); #1;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1; Req = 0; ReqWrite = 0; ReqFetch = 0;
    Addr = '0; WData = '0; DataWait = '0; Ready = 1; AdIn = '0;
    #2;
    repeat (2) begin
      checks++;
      if ({ALE, nME, nOE, nWE, AdOe, Busy, Done, Error} !== 8'b0111_0000
          || AdOut !== 16'h0 || RData !== 16'h0) begin
        errors++;
        $display("FAIL reset pins=%b adout=%h rdata=%h",
                 {ALE, nME, nOE, nWE, AdOe, Busy, Done, Error},
                 AdOut, RData);
      end
      @(posedge Clock); #1;
    end
    @(negedge Clock); Reset = 0;
    @(posedge Clock); #1;
  endtask

  task automatic test_zero_wait_read();
    run_txn(0, 0, 16'h1234, 16'h0, 4'd0, '1, 0, 1, 16'hBEEF, "rd0");
    checks++;
    if (RData !== 16'hBEEF) begin
      errors++;
      $display("FAIL rd0_value got=%h want=beef", RData);
    end
  endtask

  task automatic test_write_wait3();
    run_txn(1, 0, 16'h0040, 16'hA5A5, 4'd3, '1, 0, 0, '0, "wr3");
  endtask

  task automatic test_fetch();
    run_txn(0, 1, 16'h0100, 16'h0, 4'd9, '1, 0, 0, '0, "fetch");
    run_txn(1, 1, 16'h0102, 16'h5A5A, 4'd1, '1, 0, 0, '0, "wrfetch");
  endtask

  task automatic test_timeout();
    run_txn(0, 0, 16'h0200, 16'h0, 4'd0, '0, 0, 0, '0, "tmo_rd");
    run_txn(1, 0, 16'h0202, 16'h1111, 4'd2, '0, 0, 0, '0, "tmo_wr");
    run_txn(0, 0, 16'h0204, 16'h0, 4'd1, 32'h0000_0040, 0, 0, '0,
            "late_rdy");
  endtask

  task automatic test_reset_mid();
    Req = 1; ReqWrite = 1; ReqFetch = 0;
    Addr = 16'h0300; WData = 16'hC3C3; DataWait = 4'd5; Ready = 1;
    @(posedge Clock); #1;
    Req = 0;
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if (nWE !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre nWE=%b Busy=%b want 0/1", nWE, Busy);
    end
    Reset = 1;
    #1;
    rdata_exp = '0;
    checks++;
    if ({ALE, nME, nOE, nWE, AdOe, Busy, Done, Error} !== 8'b0111_0000
        || AdOut !== 16'h0 || RData !== 16'h0) begin
      errors++;
      $display("FAIL rstmid pins=%b adout=%h rdata=%h",
               {ALE, nME, nOE, nWE, AdOe, Busy, Done, Error},
               AdOut, RData);
    end
    @(negedge Clock); Reset = 0;
    repeat (3) begin
      @(posedge Clock); #1;
      checks++;
      if (Done !== 1'b0 || Error !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_after Done=%b Error=%b Busy=%b",
                 Done, Error, Busy);
      end
    end
    run_txn(0, 0, 16'h0310, 16'h0, 4'd0, '1, 0, 0, '0, "rd_after_rst");
  endtask

  task automatic test_back_to_back();
    int d1;
    run_txn(0, 0, 16'h0400, 16'h0, 4'd0, '1, 1, 0, '0, "b2b_1");
    d1 = last_done;
    run_txn(0, 0, 16'h0402, 16'h0, 4'd0, '1, 0, 0, '0, "b2b_2");
    checks++;
    if (last_done - d1 !== 5) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d want=5", last_done - d1);
    end
  endtask

  task automatic test_random();
    logic [31:0] m;
    for (int i = 0; i < 40; i++) begin
      m = $urandom | $urandom;
      if ($urandom_range(0, 7) == 0) m = '0;
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              4'($urandom), m, 1'($urandom), 0, '0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait3();
    test_fetch();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    Req = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
